partition_rasterizer: RTL and testbench

//  Synthesizable, streaming successor to the per-frame software render loop.

---
 rtl/partition_rasterizer.sv | 194 +++++++++++++++++++
 tb/tb_partition_rasterizer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/partition_rasterizer.sv
// partition_rasterizer: streams a frame in row-major order, testing each pixel
// against its tile's triangles (edge functions + depth compare) before emitting it.
module partition_rasterizer #(
    parameter int RES_X    = 64,
    parameter int RES_Y    = 64,
    parameter int PARTS    = 4,
    parameter int MAX_TRIS = 16,
    parameter int COORD_W  = 12,
    parameter int Z_W      = 16,
    parameter int CW       = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start_i,
    input  logic [3*CW-1:0]                               fill_rgb_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          cnt_rd_o,
    output logic [$clog2(PARTS*PARTS)-1:0]                cnt_addr_o,
    input  logic [$clog2(MAX_TRIS):0]                     cnt_data_i,
    output logic                                          tri_rd_o,
    output logic [$clog2(PARTS*PARTS)+$clog2(MAX_TRIS)-1:0] tri_addr_o,
    input  logic [3*CW+Z_W+6*COORD_W-1:0]                 tri_data_i,
    output logic                                          pix_valid_o,
    input  logic                                          pix_ready_i,
    output logic [$clog2(RES_X)-1:0]                      pix_x_o,
    output logic [$clog2(RES_Y)-1:0]                      pix_y_o,
    output logic [3*CW-1:0]                               pix_rgb_o,
    output logic                                          pix_last_o
);
    localparam int CA_W  = $clog2(PARTS*PARTS);
    localparam int SL_W  = $clog2(MAX_TRIS);
    localparam int CNT_W = SL_W + 1;
    localparam int X_W   = $clog2(RES_X);
    localparam int Y_W   = $clog2(RES_Y);
    localparam int TRI_W = 3*CW + Z_W + 6*COORD_W;
    localparam int TW    = RES_X / PARTS;
    localparam int TH    = RES_Y / PARTS;
    localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int EW    = 2*COORD_W + 2;

    typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, TRI_REQ, TRI_WAIT, TEST, EMIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, tx_q;
    logic [Y_W-1:0]     y_q, ty_q;
    logic [PW-1:0]      parx_q, pary_q;
    logic [SL_W-1:0]    slot_q;
    logic [CNT_W-1:0]   cnt_q, cnt_sat;
    logic [TRI_W-1:0]   tri_q;
    logic               hit_q;
    logic [Z_W-1:0]     best_z_q, tri_z;
    logic [3*CW-1:0]    fill_q, best_rgb_q, tri_rgb;
    logic               busy_q, done_q, cnt_rd_q, tri_rd_q, pix_valid_q, pix_last_q;
    logic               last_pix, more_tris, accept, tri_hit, take, pos, neg;
    logic signed [EW-1:0] px, py, x0, y0, x1, y1, x2, y2, e0, e1, e2, area;

    function automatic logic signed [EW-1:0] sx(input logic [COORD_W-1:0] c);
        return {{(EW-COORD_W){c[COORD_W-1]}}, c};
    endfunction

    function automatic logic signed [EW-1:0] edge_fn(input logic signed [EW-1:0] qx, qy, xa, ya, xb, yb);
        return (qx - xa) * (yb - ya) - (qy - ya) * (xb - xa);
    endfunction

    assign px      = {{(EW-X_W){1'b0}}, x_q};
    assign py      = {{(EW-Y_W){1'b0}}, y_q};
    assign x0      = sx(tri_q[5*COORD_W +: COORD_W]);
    assign y0      = sx(tri_q[4*COORD_W +: COORD_W]);
    assign x1      = sx(tri_q[3*COORD_W +: COORD_W]);
    assign y1      = sx(tri_q[2*COORD_W +: COORD_W]);
    assign x2      = sx(tri_q[1*COORD_W +: COORD_W]);
    assign y2      = sx(tri_q[0 +: COORD_W]);
    assign tri_z   = tri_q[6*COORD_W +: Z_W];
    assign tri_rgb = tri_q[6*COORD_W+Z_W +: 3*CW];
    assign e0      = edge_fn(px, py, x0, y0, x1, y1);
    assign e1      = edge_fn(px, py, x1, y1, x2, y2);
    assign e2      = edge_fn(px, py, x2, y2, x0, y0);
    assign area    = edge_fn(x2, y2, x0, y0, x1, y1);
    // Accepting either sign makes the test winding-independent; zero counts for both.
    assign pos     = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
    assign neg     = (e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0);
    assign tri_hit = (area != '0) && (pos || neg);
    assign take    = tri_hit && (!hit_q || tri_z < best_z_q);

    assign cnt_sat   = (cnt_data_i > CNT_W'(MAX_TRIS)) ? CNT_W'(MAX_TRIS) : cnt_data_i;
    assign more_tris = (CNT_W'(slot_q) + CNT_W'(1)) < cnt_q;
    assign last_pix  = (x_q == X_W'(RES_X-1)) && (y_q == Y_W'(RES_Y-1));
    assign accept    = (state_q == EMIT) && pix_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = start_i ? CNT_REQ : IDLE;
            CNT_REQ:  state_d = CNT_WAIT;
            CNT_WAIT: state_d = (cnt_sat == '0) ? EMIT : TRI_REQ;
            TRI_REQ:  state_d = TRI_WAIT;
            TRI_WAIT: state_d = TEST;
            TEST:     state_d = more_tris ? TRI_REQ : EMIT;
            EMIT:     state_d = pix_ready_i ? (last_pix ? DONE : CNT_REQ) : EMIT;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            tx_q        <= '0;
            y_q         <= '0;
            ty_q        <= '0;
            parx_q      <= '0;
            pary_q      <= '0;
            slot_q      <= '0;
            cnt_q       <= '0;
            tri_q       <= '0;
            hit_q       <= 1'b0;
            best_z_q    <= '0;
            fill_q      <= '0;
            best_rgb_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_rd_q    <= 1'b0;
            tri_rd_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= state_d != IDLE;
            done_q      <= state_d == DONE;
            cnt_rd_q    <= state_d == CNT_REQ;
            tri_rd_q    <= state_d == TRI_REQ;
            pix_valid_q <= state_d == EMIT;
            pix_last_q  <= (state_d == EMIT) && last_pix;
            if (state_q == IDLE && start_i) fill_q <= fill_rgb_i;
            if (state_q == CNT_REQ) begin
                hit_q      <= 1'b0;
                slot_q     <= '0;
                best_rgb_q <= fill_q;
            end
            if (state_q == CNT_WAIT) cnt_q <= cnt_sat;
            if (state_q == TRI_WAIT) tri_q <= tri_data_i;
            if (state_q == TEST) begin
                if (take) begin
                    hit_q      <= 1'b1;
                    best_z_q   <= tri_z;
                    best_rgb_q <= tri_rgb;
                end
                if (more_tris) slot_q <= slot_q + 1'b1;
            end
            // Tile counters track x/(RES_X/PARTS) and y/(RES_Y/PARTS) without dividing.
            if (accept) begin
                if (x_q == X_W'(RES_X-1)) begin
                    x_q    <= '0;
                    tx_q   <= '0;
                    parx_q <= '0;
                    if (y_q == Y_W'(RES_Y-1)) begin
                        y_q    <= '0;
                        ty_q   <= '0;
                        pary_q <= '0;
                    end else begin
                        y_q <= y_q + 1'b1;
                        if (ty_q == Y_W'(TH-1)) begin
                            ty_q   <= '0;
                            pary_q <= pary_q + 1'b1;
                        end else begin
                            ty_q <= ty_q + 1'b1;
                        end
                    end
                end else begin
                    x_q <= x_q + 1'b1;
                    if (tx_q == X_W'(TW-1)) begin
                        tx_q   <= '0;
                        parx_q <= parx_q + 1'b1;
                    end else begin
                        tx_q <= tx_q + 1'b1;
                    end
                end
            end
        end
    end

    assign cnt_addr_o  = CA_W'(pary_q) * CA_W'(PARTS) + CA_W'(parx_q);
    assign tri_addr_o  = {cnt_addr_o, slot_q};
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cnt_rd_o    = cnt_rd_q;
    assign tri_rd_o    = tri_rd_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_last_o  = pix_last_q;
    assign pix_x_o     = x_q;
    assign pix_y_o     = y_q;
    assign pix_rgb_o   = best_rgb_q;
endmodule

// File: tb/tb_partition_rasterizer.sv
// tb_partition_rasterizer: directed frames on an 8x8 / 2x2-tile configuration with
// a 1-cycle-latency memory model and hand-derived expected pixels.
module tb_partition_rasterizer;
    localparam logic [23:0] FILL = 24'h102030;
    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] BLUE = 24'h0000FF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [23:0]  fill_rgb = FILL;
    logic         busy, done, cnt_rd, tri_rd, pix_valid, pix_last;
    logic         pix_ready = 1'b1;
    logic [1:0]   cnt_addr;
    logic [4:0]   cnt_data = '0;
    logic [5:0]   tri_addr;
    logic [111:0] tri_data = '0;
    logic [2:0]   pix_x, pix_y;
    logic [23:0]  pix_rgb;

    logic [4:0]   cnt_mem[4];
    logic [111:0] tri_mem[64];
    logic [2:0]   gx[64], gy[64];
    logic [23:0]  grgb[64];
    logic         glast[64];
    int           vectors = 0;
    int           miscompares = 0;
    int           ac;

    partition_rasterizer #(
        .RES_X(8), .RES_Y(8), .PARTS(2), .MAX_TRIS(16), .COORD_W(12), .Z_W(16), .CW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .fill_rgb_i(fill_rgb),
        .busy_o(busy), .done_o(done),
        .cnt_rd_o(cnt_rd), .cnt_addr_o(cnt_addr), .cnt_data_i(cnt_data),
        .tri_rd_o(tri_rd), .tri_addr_o(tri_addr), .tri_data_i(tri_data),
        .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
        .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_rgb_o(pix_rgb), .pix_last_o(pix_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_rd) cnt_data <= cnt_mem[cnt_addr];
        if (tri_rd) tri_data <= tri_mem[tri_addr];
    end

    function automatic logic [111:0] tp(input logic [23:0] rgb, input logic [15:0] z,
                                        input int x0, y0, x1, y1, x2, y2);
        return {rgb, z, 12'(x0), 12'(y0), 12'(x1), 12'(y1), 12'(x2), 12'(y2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) cnt_mem[i] = '0;
        for (int i = 0; i < 64; i++) tri_mem[i] = '0;
    endtask

    task automatic frame(input int stall_idx, input int abort_idx, output int acc_cyc);
        int n = 0, cyc = 0, held = 0, dn = 0;
        logic [31:0] snap = '0;
        acc_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            gx[i] = '0; gy[i] = '0; grgb[i] = '0; glast[i] = 1'b0;
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (n < 64 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (done) dn++;
            if (pix_valid) begin
                if (n == abort_idx) begin
                    rst_n = 1'b0;
                    break;
                end
                if (n == stall_idx && held < 5) begin
                    pix_ready = 1'b0;
                    if (held == 0) snap = {pix_x, pix_y, pix_rgb, pix_last};
                    else chk("stall_hold", {pix_x, pix_y, pix_rgb, pix_last}, snap);
                    held++;
                end else begin
                    pix_ready = 1'b1;
                    gx[n] = pix_x; gy[n] = pix_y; grgb[n] = pix_rgb; glast[n] = pix_last;
                    n++;
                    acc_cyc = cyc;
                end
            end
        end
        chk("pixel_count", n, (abort_idx >= 0) ? abort_idx : 64);
        chk("early_done", dn, 0);
        if (abort_idx < 0) begin
            @(negedge clk);
            chk("done_pulse", {busy, done}, 2'b11);
            @(negedge clk);
            chk("done_clear", {busy, done}, 2'b00);
        end
    endtask

    task automatic check_frame(input string tg, input logic [23:0] quad);
        for (int i = 0; i < 64; i++) begin
            chk({tg, "_x"}, gx[i], i % 8);
            chk({tg, "_y"}, gy[i], i / 8);
            chk({tg, "_rgb"}, grgb[i], (i % 8 <= 3 && i / 8 <= 3) ? quad : FILL);
            chk({tg, "_last"}, glast[i], i == 63);
        end
    endtask

    initial begin
        clear_mem();
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {busy, done, cnt_rd, tri_rd, pix_valid, pix_last, pix_x, pix_y, cnt_addr, tri_addr}, 0);
        chk("reset_rgb", pix_rgb, 0);
        rst_n = 1'b1;
        @(negedge clk);

        frame(-1, -1, ac);
        check_frame("empty", FILL);
        chk("throughput", ac, 191);

        cnt_mem[0] = 5'd1;
        tri_mem[0] = tp(RED, 16'd0, 0, 0, 7, 0, 0, 7);
        frame(-1, -1, ac);
        check_frame("one_tri", RED);

        cnt_mem[0] = 5'd2;
        tri_mem[0] = tp(RED, 16'd10, 0, 0, 7, 0, 0, 7);
        tri_mem[1] = tp(BLUE, 16'd5, 0, 0, 7, 0, 0, 7);
        frame(-1, -1, ac);
        check_frame("nearer_wins", BLUE);

        tri_mem[0] = tp(RED, 16'd7, 0, 0, 7, 0, 0, 7);
        tri_mem[1] = tp(BLUE, 16'd7, 0, 0, 7, 0, 0, 7);
        frame(-1, -1, ac);
        check_frame("tie_low_slot", RED);

        cnt_mem[0] = 5'd1;
        tri_mem[0] = tp(RED, 16'd0, 0, 0, 0, 7, 7, 0);
        frame(-1, -1, ac);
        check_frame("clockwise", RED);

        tri_mem[0] = tp(RED, 16'd0, 0, 0, 2, 2, 4, 4);
        frame(-1, -1, ac);
        check_frame("collinear", FILL);

        tri_mem[0] = tp(RED, 16'd0, 0, 0, 7, 0, 0, 7);
        frame(3, -1, ac);
        check_frame("stall", RED);

        frame(-1, 20, ac);
        @(negedge clk);
        chk("abort_ctrl", {busy, done, cnt_rd, tri_rd, pix_valid, pix_last, pix_x, pix_y, cnt_addr, tri_addr}, 0);
        chk("abort_rgb", pix_rgb, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {busy, done}, 2'b00);
        end
        frame(-1, -1, ac);
        check_frame("restart", RED);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
